// File: rtl/render_pkg.sv
// Shared types and constants for the sprite render datapath: FSM states,
// command identifiers and pixel colours.
package render_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLOOR = 3'd1,
    S_MAN   = 3'd2,
    S_ERASE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_FLOOR = 2'd0,
    CMD_MAN   = 2'd1,
    CMD_ERASE = 2'd2
  } cmd_t;

  localparam logic [2:0] FLOOR_C = 3'b010;
  localparam logic [2:0] MAN_C   = 3'b111;
  localparam logic [2:0] BG_C    = 3'b000;

endpackage

// File: rtl/man_sprite_rom.sv
// Combinational 4-style x 8-row x 4-column bitmap of the running man.
// Bit {row,col} of each style word is the pixel; row 0 is the head.
module man_sprite_rom (
  input  logic [1:0] style_i,
  input  logic [2:0] row_i,
  input  logic [1:0] col_i,
  output logic       pixel_o
);

  logic [31:0] word;

  always_comb begin
    case (style_i)
      2'd0:    word = 32'h9966_6F66;
      2'd1:    word = 32'h5A66_7E66;
      2'd2:    word = 32'h6666_6F66;
      default: word = 32'hA566_E766;
    endcase
    pixel_o = word[{row_i, col_i}];
  end

endmodule

// File: rtl/sprite_render_engine.sv
// Pixel generator for the runner game: holds the man's position/style and
// scans the floor band, the man sprite or its erase box one pixel per cycle.
module sprite_render_engine
  import render_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPR_W    = 4,
  parameter int SPR_H    = 8,
  parameter int FLOOR_Y  = 100,
  parameter int FLOOR_T  = 2,
  parameter int STEP     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       drawing_floors,
  input  logic       draw_man,
  input  logic       erase,
  input  logic       ld_x,
  input  logic       ld_y,
  input  logic       ld_man_style,
  input  logic       update,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [1:0] style_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       draw_floors_finish,
  output logic       drawing_man_finish,
  output logic       erase_finish
);

  localparam logic [8:0] X_MAX     = 9'(SCREEN_W - SPR_W);
  localparam logic [8:0] X_LIM     = 9'(SCREEN_W);
  localparam logic [8:0] Y_LIM     = 9'(SCREEN_H);
  localparam logic [7:0] FCOL_LAST = 8'(SCREEN_W - 1);
  localparam logic [7:0] SCOL_LAST = 8'(SPR_W - 1);
  localparam logic [2:0] FROW_LAST = 3'(FLOOR_T - 1);
  localparam logic [2:0] SROW_LAST = 3'(SPR_H - 1);
  localparam logic [6:0] FLOOR_Y7  = 7'(FLOOR_Y);
  localparam logic [6:0] MAN_Y_RST = 7'(FLOOR_Y - SPR_H);

  logic [7:0] man_x_q, man_x_d;
  logic [6:0] man_y_q, man_y_d;
  logic [1:0] man_style_q, man_style_d;
  logic [8:0] x_step;

  logic [7:0] snap_x_q;
  logic [6:0] snap_y_q;
  logic [1:0] snap_style_q;

  state_t     state_q;
  cmd_t       cmd_q;
  logic [7:0] col_q, col_d;
  logic [2:0] row_q, row_d;

  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;

  logic       start;
  state_t     start_state;
  cmd_t       start_cmd;
  state_t     mode;
  logic [7:0] col_last;
  logic [2:0] row_last;
  logic       scanning, scan_last, emit, cmd_active;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [1:0] base_style;
  logic [8:0] px_x9, px_y9;
  logic       rom_bit, on_screen;
  logic [7:0] px_x;
  logic [6:0] px_y;
  logic [2:0] px_c;
  logic       px_plot;

  // Position registers; a load always beats a simultaneous update.
  assign x_step = {1'b0, man_x_q} + 9'(STEP);

  always_comb begin
    man_x_d     = man_x_q;
    man_y_d     = man_y_q;
    man_style_d = man_style_q;
    if (ld_x)
      man_x_d = x_in;
    else if (update)
      man_x_d = (x_step > X_MAX) ? 8'd0 : x_step[7:0];
    if (ld_y)
      man_y_d = y_in;
    if (ld_man_style)
      man_style_d = style_in;
    else if (update)
      man_style_d = man_style_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      man_x_q     <= 8'd0;
      man_y_q     <= MAN_Y_RST;
      man_style_q <= 2'd0;
    end else begin
      man_x_q     <= man_x_d;
      man_y_q     <= man_y_d;
      man_style_q <= man_style_d;
    end
  end

  always_comb begin
    start       = 1'b1;
    start_state = S_FLOOR;
    start_cmd   = CMD_FLOOR;
    if (drawing_floors) begin
      start_state = S_FLOOR;
      start_cmd   = CMD_FLOOR;
    end else if (erase) begin
      start_state = S_ERASE;
      start_cmd   = CMD_ERASE;
    end else if (draw_man) begin
      start_state = S_MAN;
      start_cmd   = CMD_MAN;
    end else begin
      start = 1'b0;
    end
  end

  always_comb begin
    case (cmd_q)
      CMD_FLOOR: cmd_active = drawing_floors;
      CMD_MAN:   cmd_active = draw_man;
      CMD_ERASE: cmd_active = erase;
      default:   cmd_active = 1'b0;
    endcase
  end

  // The registered outputs always carry the pixel for the counters' next
  // value, so the first pixel appears the cycle after the command is taken.
  always_comb begin
    mode      = (state_q == S_IDLE) ? start_state : state_q;
    scanning  = (state_q == S_FLOOR) || (state_q == S_MAN) || (state_q == S_ERASE);
    col_last  = (mode == S_FLOOR) ? FCOL_LAST : SCOL_LAST;
    row_last  = (mode == S_FLOOR) ? FROW_LAST : SROW_LAST;
    scan_last = (col_q == col_last) && (row_q == row_last);
    if (state_q == S_IDLE) begin
      col_d = 8'd0;
      row_d = 3'd0;
    end else if (col_q == col_last) begin
      col_d = 8'd0;
      row_d = row_q + 3'd1;
    end else begin
      col_d = col_q + 8'd1;
      row_d = row_q;
    end
    emit       = (state_q == S_IDLE) ? start : (scanning && !scan_last);
    base_x     = (state_q == S_IDLE) ? man_x_q : snap_x_q;
    base_y     = (state_q == S_IDLE) ? man_y_q : snap_y_q;
    base_style = (state_q == S_IDLE) ? man_style_q : snap_style_q;
  end

  man_sprite_rom u_rom (
    .style_i (base_style),
    .row_i   (row_d),
    .col_i   (col_d[1:0]),
    .pixel_o (rom_bit)
  );

  // Sprite coordinates are 9 bits so off-screen pixels clip instead of wrapping.
  always_comb begin
    px_x9     = {1'b0, base_x} + {1'b0, col_d};
    px_y9     = {2'b00, base_y} + {6'd0, row_d};
    on_screen = (px_x9 < X_LIM) && (px_y9 < Y_LIM);
    px_x      = 8'd0;
    px_y      = 7'd0;
    px_c      = BG_C;
    px_plot   = 1'b0;
    if (emit) begin
      case (mode)
        S_FLOOR: begin
          px_x    = col_d;
          px_y    = FLOOR_Y7 + {4'd0, row_d};
          px_c    = FLOOR_C;
          px_plot = 1'b1;
        end
        S_MAN: begin
          px_x    = px_x9[7:0];
          px_y    = px_y9[6:0];
          px_c    = MAN_C;
          px_plot = rom_bit && on_screen;
        end
        S_ERASE: begin
          px_x    = px_x9[7:0];
          px_y    = px_y9[6:0];
          px_c    = BG_C;
          px_plot = on_screen;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= CMD_FLOOR;
      col_q        <= 8'd0;
      row_q        <= 3'd0;
      snap_x_q     <= 8'd0;
      snap_y_q     <= 7'd0;
      snap_style_q <= 2'd0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 3'd0;
      plot_q       <= 1'b0;
    end else begin
      x_q      <= px_x;
      y_q      <= px_y;
      colour_q <= px_c;
      plot_q   <= px_plot;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= start_state;
            cmd_q        <= start_cmd;
            col_q        <= col_d;
            row_q        <= row_d;
            snap_x_q     <= man_x_q;
            snap_y_q     <= man_y_q;
            snap_style_q <= man_style_q;
          end
        end
        S_FLOOR, S_MAN, S_ERASE: begin
          if (scan_last) begin
            state_q <= S_DONE;
          end else begin
            col_q <= col_d;
            row_q <= row_d;
          end
        end
        S_DONE: begin
          if (!cmd_active)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_out  = x_q;
  assign y_out  = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

  assign draw_floors_finish = (state_q == S_DONE) && (cmd_q == CMD_FLOOR);
  assign drawing_man_finish = (state_q == S_DONE) && (cmd_q == CMD_MAN);
  assign erase_finish       = (state_q == S_DONE) && (cmd_q == CMD_ERASE);

endmodule

// File: tb/tb_sprite_render_engine.sv
// Directed + randomized bench for sprite_render_engine against a pixel-list
// reference model of the floor/man/erase scans.
module tb_sprite_render_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       drawing_floors = 1'b0, draw_man = 1'b0, erase = 1'b0;
  logic       ld_x = 1'b0, ld_y = 1'b0, ld_man_style = 1'b0, update = 1'b0;
  logic [7:0] x_in = 8'd0;
  logic [6:0] y_in = 7'd0;
  logic [1:0] style_in = 2'd0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       draw_floors_finish, drawing_man_finish, erase_finish;

  int total = 0;
  int bad = 0;

  // Reference position state.
  int mx = 0, my = 92, ms = 0;

  typedef struct {int x; int y; int c;} px_t;

  // Sprite rows, bit c of each nibble is column c.
  logic [3:0] spr [4][8] = '{
    '{4'b0110, 4'b0110, 4'b1111, 4'b0110, 4'b0110, 4'b0110, 4'b1001, 4'b1001},
    '{4'b0110, 4'b0110, 4'b1110, 4'b0111, 4'b0110, 4'b0110, 4'b1010, 4'b0101},
    '{4'b0110, 4'b0110, 4'b1111, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110},
    '{4'b0110, 4'b0110, 4'b0111, 4'b1110, 4'b0110, 4'b0110, 4'b0101, 4'b1010}
  };

  sprite_render_engine dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .drawing_floors     (drawing_floors),
    .draw_man           (draw_man),
    .erase              (erase),
    .ld_x               (ld_x),
    .ld_y               (ld_y),
    .ld_man_style       (ld_man_style),
    .update             (update),
    .x_in               (x_in),
    .y_in               (y_in),
    .style_in           (style_in),
    .x_out              (x_out),
    .y_out              (y_out),
    .colour             (colour),
    .plot               (plot),
    .draw_floors_finish (draw_floors_finish),
    .drawing_man_finish (drawing_man_finish),
    .erase_finish       (erase_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, ex);
    end
  endtask

  function automatic logic [2:0] fin_vec();
    return {draw_floors_finish, drawing_man_finish, erase_finish};
  endfunction

  // One-cycle pulse of position controls, then update the reference model.
  task automatic pos_op(input bit lx, input bit ly, input bit ls, input bit up,
                        input int xv, input int yv, input int sv);
    @(posedge clk); #1;
    ld_x = lx; ld_y = ly; ld_man_style = ls; update = up;
    x_in = 8'(xv); y_in = 7'(yv); style_in = 2'(sv);
    @(posedge clk); #1;
    ld_x = 0; ld_y = 0; ld_man_style = 0; update = 0;
    if (lx) mx = xv;
    else if (up) begin
      mx = mx + 2;
      if (mx > 156) mx = 0;
    end
    if (ly) my = yv;
    if (ls) ms = sv;
    else if (up) ms = (ms + 1) % 4;
  endtask

  // which: 0 floor, 1 man, 2 erase, 3 man+erase together (erase wins).
  task automatic run_cmd(input string tag, input int which, input int hold_extra, input int mid_ldx);
    px_t ex_q[$];
    px_t got_q[$];
    px_t p;
    int kind, ncyc, first_fin, mism, first_bad, extra_plots, fin_bad;
    logic [2:0] fin_exp, fin_at;
    kind = (which == 3) ? 2 : which;
    fin_exp = (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001;
    if (kind == 0) begin
      ncyc = 320;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 160; c++) begin
          p.x = c; p.y = 100 + r; p.c = 2; ex_q.push_back(p);
        end
    end else begin
      ncyc = 32;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 4; c++) begin
          p.x = mx + c; p.y = my + r; p.c = (kind == 1) ? 7 : 0;
          if (p.x < 160 && p.y < 120 && (kind == 2 || spr[ms][r][c] == 1'b1))
            ex_q.push_back(p);
        end
    end
    @(posedge clk); #1;
    drawing_floors = (which == 0);
    draw_man = (which == 1 || which == 3);
    erase = (which == 2 || which == 3);
    first_fin = -1;
    fin_at = 3'b000;
    for (int i = 0; i < ncyc + 20 && first_fin < 0; i++) begin
      @(negedge clk);
      if (plot === 1'b1) begin
        p.x = int'(x_out); p.y = int'(y_out); p.c = int'(colour);
        got_q.push_back(p);
      end
      if (fin_vec() !== 3'b000) begin
        first_fin = i;
        fin_at = fin_vec();
      end
      if (mid_ldx >= 0 && i == mid_ldx) begin
        ld_x = 1; x_in = 8'd50;
      end
      if (mid_ldx >= 0 && i == mid_ldx + 1) begin
        ld_x = 0; mx = 50;
      end
    end
    check({tag, "_fin_latency"}, first_fin, ncyc + 1);
    check({tag, "_fin_flags"}, fin_at, fin_exp);
    check({tag, "_plot_count"}, got_q.size(), ex_q.size());
    mism = 0;
    first_bad = -1;
    for (int k = 0; k < ex_q.size() && k < got_q.size(); k++)
      if (got_q[k].x != ex_q[k].x || got_q[k].y != ex_q[k].y || got_q[k].c != ex_q[k].c) begin
        mism++;
        if (first_bad < 0) first_bad = k;
      end
    if (first_bad >= 0)
      $display("first differing pixel %0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", first_bad,
               got_q[first_bad].x, got_q[first_bad].y, got_q[first_bad].c,
               ex_q[first_bad].x, ex_q[first_bad].y, ex_q[first_bad].c);
    check({tag, "_pixel_errors"}, mism, 0);
    extra_plots = 0;
    fin_bad = 0;
    for (int j = 0; j < hold_extra; j++) begin
      @(negedge clk);
      if (plot !== 1'b0) extra_plots++;
      if (fin_vec() !== fin_exp) fin_bad++;
    end
    if (hold_extra > 0) begin
      check({tag, "_held_no_rescan"}, extra_plots, 0);
      check({tag, "_held_finish"}, fin_bad, 0);
    end
    @(posedge clk); #1;
    drawing_floors = 0; draw_man = 0; erase = 0;
    @(negedge clk);
    check({tag, "_fin_release_cycle"}, fin_vec(), fin_exp);
    @(negedge clk);
    check({tag, "_fin_after_release"}, fin_vec(), 3'b000);
  endtask

  initial begin
    int rx, ry, rs, nup, rk;
    reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_colour", colour, 0);
    check("rst_plot", plot, 0);
    check("rst_finish", fin_vec(), 0);
    @(posedge clk); #1;
    reset_n = 1;

    run_cmd("floor", 0, 2, -1);

    pos_op(1, 1, 1, 0, 20, 92, 1);
    run_cmd("man_20_92_s1", 1, 0, -1);

    pos_op(1, 0, 0, 0, 158, 0, 0);
    run_cmd("erase_clip_158", 2, 0, -1);

    pos_op(1, 0, 0, 0, 154, 0, 0);
    pos_op(0, 0, 0, 1, 0, 0, 0);
    run_cmd("man_after_upd1", 1, 0, -1);
    pos_op(0, 0, 0, 1, 0, 0, 0);
    run_cmd("man_after_upd2", 1, 0, -1);

    run_cmd("erase_prio_snap", 3, 40, 5);
    run_cmd("man_after_midld", 1, 0, -1);

    for (int it = 0; it < 6; it++) begin
      rx = (it % 2 == 1) ? $urandom_range(150, 159) : $urandom_range(0, 159);
      ry = (it % 3 == 2) ? $urandom_range(110, 119) : $urandom_range(0, 119);
      rs = $urandom_range(0, 3);
      pos_op(1, 1, 1, 0, rx, ry, rs);
      nup = $urandom_range(0, 3);
      for (int u = 0; u < nup; u++) pos_op(0, 0, 0, 1, 0, 0, 0);
      rk = $urandom_range(1, 2);
      run_cmd($sformatf("rand%0d", it), rk, 0, -1);
    end

    // Reset in the middle of a man scan.
    pos_op(1, 1, 1, 0, 40, 50, 2);
    @(posedge clk); #1;
    draw_man = 1;
    for (int i = 0; i <= 10; i++) @(negedge clk);
    reset_n = 0;
    draw_man = 0;
    @(negedge clk);
    check("midrst_plot", plot, 0);
    check("midrst_finish", fin_vec(), 0);
    check("midrst_x_out", x_out, 0);
    @(posedge clk); #1;
    reset_n = 1;
    mx = 0; my = 92; ms = 0;
    run_cmd("man_after_reset", 1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
